lcd_if: RTL and testbench
=========================

LCD_IF -- requirements
Module: lcd_if

Interface
REQ-001 The block SHALL have the parameter T_SETUP, default 4, which is the clk_i cycles from RS/data valid to EN rise.
REQ-002 The block SHALL have the parameter T_PULSE, default 12, which is the EN high width in cycles.
REQ-003 The block SHALL have the parameter T_HOLD, default 2, which is the cycles RS/data are held after EN fall.
REQ-004 The block SHALL have the parameter T_EXEC, default 2000, which is the busy wait after a normal command or data byte (40 us at 50 MHz).
REQ-005 The block SHALL have the parameter T_LONG, default 82000, which is the busy wait after clear (0x01) or home (0x02) with RS=0.
REQ-006 clk_i  input  1  system clock.
REQ-007 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-008 lcd_reg_i  input  32  LCD register from the load/store unit: [31]=ON, [10]=GO, [9]=RS, [7:0]=DATA; other bits ignored.
REQ-009 lcd_on_o  output  1  panel/backlight enable.
REQ-010 lcd_rs_o  output  1  register select to the panel.
REQ-011 lcd_rw_o  output  1  read/write; constant 0 (write-only).
REQ-012 lcd_en_o  output  1  enable strobe.
REQ-013 lcd_data_o  output  8  data bus.
REQ-014 done_o  output  1  one-cycle pulse at the end of each transaction.
REQ-015 status_o  output  32  {29'b0, ovf, pend, busy}, returned to the load path.

Function
REQ-016 A request SHALL be a 0->1 transition of lcd_reg_i[10] between consecutive clk_i samples; the RS/DATA captured are those on the same edge.
REQ-017 lcd_on_o SHALL equal lcd_reg_i[31] registered, with 1-cycle latency, independent of the FSM.
REQ-018 The FSM SHALL have states IDLE, SETUP, PULSE, HOLD, EXEC.
REQ-019 From IDLE, a request SHALL move the FSM to SETUP and drive lcd_rs_o/lcd_data_o on that edge.
REQ-020 SETUP SHALL last T_SETUP cycles with EN=0, then the FSM SHALL enter PULSE.
REQ-021 PULSE SHALL last T_PULSE cycles with EN=1, then the FSM SHALL enter HOLD.
REQ-022 HOLD SHALL last T_HOLD cycles with EN=0 and data held, then the FSM SHALL enter EXEC.
REQ-023 EXEC SHALL last T_LONG cycles if the request is RS=0 with DATA 0x01 or 0x02, otherwise T_EXEC cycles.
REQ-024 On the last EXEC cycle, done_o SHALL pulse; the FSM SHALL then go to SETUP if a pending or same-cycle request exists, else to IDLE.
REQ-025 busy SHALL be 1 in every non-IDLE state.
REQ-026 A request while busy SHALL fill a one-entry pending slot (pend=1).
REQ-027 A request while pend=1 SHALL be dropped and set ovf sticky.
REQ-028 ovf SHALL clear only on reset or when a request is accepted from IDLE.
REQ-029 A request on the last EXEC cycle with pend=0 SHALL launch directly without touching pend; with pend=1, the pending entry SHALL launch first and the new request SHALL take the slot.
REQ-030 lcd_rs_o/lcd_data_o SHALL hold the last transaction's values in IDLE.
REQ-031 A single down-counter of 17 bits SHALL serve all phases, reloaded at each state entry with (phase length - 1).

Reset
REQ-032 On rst_n_i low, all outputs, state=IDLE, counter, pend, ovf and the pending slot SHALL clear to 0 immediately.
REQ-033 On rst_n_i low, the GO history register SHALL reset to 1, so a GO held high through reset does not trigger a request.
REQ-034 Reset mid-transaction SHALL abort it: EN drops to 0 at once and no done_o is produced.

Structure
REQ-035 Package lcd_pkg SHALL hold the state enum, the bit-position constants (ON=31, GO=10, RS=9, DATA=7:0), the CLR/HOME opcodes and the default timing constants.
REQ-036 The counter SHALL be the sub-module lcd_timer (load, count-down, expire flag), instantiated once.

Verification
REQ-037 Reset, then GO 0->1 with RS=0, DATA=0x38: EN high exactly 12 cycles starting 5 cycles after capture; busy for 2018 cycles; done_o once; data_o=0x38, rs_o=0.
REQ-038 GO 0->1 with RS=0, DATA=0x01: busy for 82018 cycles; done_o at the end.
REQ-039 Two requests 100 cycles apart (0x41 then 0x42, RS=1): second held in pend; EN pulses separated by exactly 2006 cycles; ovf=0.
REQ-040 Three requests during one transaction: third dropped, status_o=32'h7 while busy; ovf stays 1 until next accepted request from IDLE.
REQ-041 Reset asserted during PULSE: EN=0 immediately; status_o=0; GO held high through reset starts no transaction until it toggles low then high.
REQ-042 Toggle lcd_reg_i[31] while idle and while busy: lcd_on_o follows with 1-cycle latency; FSM unaffected.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write interface.
// Bit positions refer to the 32-bit LCD register written by the load/store unit.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_EXEC  = 3'd4
  } lcd_state_e;

  localparam int BIT_ON   = 31;
  localparam int BIT_GO   = 10;
  localparam int BIT_RS   = 9;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam logic [7:0] OP_CLR  = 8'h01;
  localparam logic [7:0] OP_HOME = 8'h02;

  localparam int DEF_T_SETUP = 4;
  localparam int DEF_T_PULSE = 12;
  localparam int DEF_T_HOLD  = 2;
  localparam int DEF_T_EXEC  = 2000;
  localparam int DEF_T_LONG  = 82000;

  localparam int CNT_W = 17;

  // Clear and home need the long execution wait; everything else is short.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == OP_CLR) || (data == OP_HOME));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Shared phase down-counter: loads (length - 1) on each state entry and
// flags expiry when it reaches zero.
module lcd_timer
  import lcd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_if.sv
// Write-only character LCD bus sequencer: setup / EN pulse / hold / busy wait,
// with a one-entry pending slot and a sticky overflow flag.
module lcd_if
  import lcd_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_EXEC  = DEF_T_EXEC,
  parameter int T_LONG  = DEF_T_LONG
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] lcd_reg_i,
  output logic        lcd_on_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic [7:0]  lcd_data_o,
  output logic        done_o,
  output logic [31:0] status_o
);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);

  lcd_state_e state_q, state_d;
  logic       go_prev_q, on_q, en_q;
  logic       rs_q, rs_d, long_q, long_d;
  logic [7:0] data_q, data_d;
  logic       pend_q, pend_d, pend_rs_q, pend_rs_d, ovf_q, ovf_d;
  logic [7:0] pend_data_q, pend_data_d;

  logic             load, expired, done, launch, launch_rs;
  logic [CNT_W-1:0] load_val;
  logic [7:0]       launch_data;

  logic       req, req_rs;
  logic [7:0] req_data;
  logic       unused_reg_bits;

  assign req      = lcd_reg_i[BIT_GO] & ~go_prev_q;
  assign req_rs   = lcd_reg_i[BIT_RS];
  assign req_data = lcd_reg_i[DATA_MSB:DATA_LSB];
  assign unused_reg_bits = ^{lcd_reg_i[30:11], lcd_reg_i[8]};

  lcd_timer u_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (load),
    .load_val_i (load_val),
    .expired_o  (expired)
  );

  always_comb begin
    state_d     = state_q;
    rs_d        = rs_q;
    data_d      = data_q;
    long_d      = long_q;
    pend_d      = pend_q;
    pend_rs_d   = pend_rs_q;
    pend_data_d = pend_data_q;
    ovf_d       = ovf_q;
    load        = 1'b0;
    load_val    = '0;
    done        = 1'b0;
    launch      = 1'b0;
    launch_rs   = req_rs;
    launch_data = req_data;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          launch = 1'b1;
          ovf_d  = 1'b0;
        end
      end
      ST_SETUP: begin
        if (expired) begin
          state_d  = ST_PULSE;
          load     = 1'b1;
          load_val = LD_PULSE;
        end
      end
      ST_PULSE: begin
        if (expired) begin
          state_d  = ST_HOLD;
          load     = 1'b1;
          load_val = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (expired) begin
          state_d  = ST_EXEC;
          load     = 1'b1;
          load_val = long_q ? LD_LONG : LD_EXEC;
        end
      end
      ST_EXEC: begin
        if (expired) begin
          done = 1'b1;
          if (pend_q) begin
            // Pending entry goes first; a same-cycle request refills the slot.
            launch      = 1'b1;
            launch_rs   = pend_rs_q;
            launch_data = pend_data_q;
            pend_d      = req;
            if (req) begin
              pend_rs_d   = req_rs;
              pend_data_d = req_data;
            end
          end else if (req) begin
            launch = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (req && (state_q != ST_IDLE) && !((state_q == ST_EXEC) && expired)) begin
      if (!pend_q) begin
        pend_d      = 1'b1;
        pend_rs_d   = req_rs;
        pend_data_d = req_data;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (launch) begin
      state_d  = ST_SETUP;
      load     = 1'b1;
      load_val = LD_SETUP;
      rs_d     = launch_rs;
      data_d   = launch_data;
      long_d   = is_long_cmd(launch_rs, launch_data);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      go_prev_q   <= 1'b1;
      on_q        <= 1'b0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      long_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      go_prev_q   <= lcd_reg_i[BIT_GO];
      on_q        <= lcd_reg_i[BIT_ON];
      en_q        <= (state_d == ST_PULSE);
      rs_q        <= rs_d;
      data_q      <= data_d;
      long_q      <= long_d;
      pend_q      <= pend_d;
      pend_rs_q   <= pend_rs_d;
      pend_data_q <= pend_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign lcd_on_o   = on_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = en_q;
  assign lcd_data_o = data_q;
  assign done_o     = done;
  assign status_o   = {29'b0, ovf_q, pend_q, (state_q != ST_IDLE)};

endmodule

// File: tb/tb_lcd_if.sv
// Scoreboard bench for lcd_if: accepted writes are queued when driven and
// checked against the bus when EN rises and when done_o pulses.
module tb_lcd_if;

  localparam int TS = 4;
  localparam int TP = 12;
  localparam int TH = 2;
  localparam int TE = 2000;
  localparam int TL = 65600;   // above 16 bits, shorter than the default to keep runtime down

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] lcd_reg_i;
  logic        lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, done_o;
  logic [7:0]  lcd_data_o;
  logic [31:0] status_o;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    int         exec;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  int   gap = 0;

  lcd_if #(
    .T_SETUP (TS),
    .T_PULSE (TP),
    .T_HOLD  (TH),
    .T_EXEC  (TE),
    .T_LONG  (TL)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .lcd_reg_i  (lcd_reg_i),
    .lcd_on_o   (lcd_on_o),
    .lcd_rs_o   (lcd_rs_o),
    .lcd_rw_o   (lcd_rw_o),
    .lcd_en_o   (lcd_en_o),
    .lcd_data_o (lcd_data_o),
    .done_o     (done_o),
    .status_o   (status_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_exec(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? TL : TE;
  endfunction

  // GO low for one cycle, then high with RS/DATA; the following posedge captures.
  task automatic issue(input logic rs, input logic [7:0] d, input bit accepted);
    @(posedge clk_i); #1;
    lcd_reg_i[10] = 1'b0;
    @(posedge clk_i); #1;
    lcd_reg_i[9]   = rs;
    lcd_reg_i[7:0] = d;
    lcd_reg_i[10]  = 1'b1;
    if (accepted) sb.push_back('{rs: rs, data: d, exec: exp_exec(rs, d)});
  endtask

  task automatic run_to_idle(input int limit, output int n, output int en_at);
    n = 0;
    en_at = -1;
    while (n < limit) begin
      @(negedge clk_i);
      if (!status_o[0]) break;
      if (lcd_en_o && en_at < 0) en_at = n;
      n++;
    end
    if (n >= limit) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic set_on(input logic v);
    logic [31:0] st;
    @(posedge clk_i); #1;
    lcd_reg_i[31] = v;
    st = status_o;
    @(negedge clk_i);
    chk("on_latency", {31'b0, lcd_on_o}, {31'b0, ~v});
    @(negedge clk_i);
    chk("on_value", {31'b0, lcd_on_o}, {31'b0, v});
    chk("on_fsm", status_o, st);
  endtask

  // Bus monitor: data valid at EN rise, EN width, EN gap, done latency and contents.
  initial begin
    int   en_cnt;
    logic en_prev;
    exp_t e;
    en_cnt  = 0;
    en_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        en_prev = 1'b0;
        en_cnt  = 0;
      end else begin
        if (lcd_en_o) begin
          if (!en_prev) begin
            rise_cyc = cyc;
            gap      = cyc - fall_cyc;
            en_cnt   = 0;
            if (sb.size() > 0) begin
              chk("en_rs", {31'b0, lcd_rs_o}, {31'b0, sb[0].rs});
              chk("en_data", {24'b0, lcd_data_o}, {24'b0, sb[0].data});
            end else begin
              chk("en_unexpected", 32'd1, 32'd0);
            end
          end
          en_cnt++;
        end else if (en_prev) begin
          fall_cyc = cyc;
          chk("en_width", en_cnt, TP);
        end
        chk("rw_const", {31'b0, lcd_rw_o}, 32'd0);
        if (done_o) begin
          n_done++;
          if (sb.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("done_rs", {31'b0, lcd_rs_o}, {31'b0, e.rs});
            chk("done_data", {24'b0, lcd_data_o}, {24'b0, e.data});
            chk("done_latency", cyc - rise_cyc, TP + TH + e.exec - 1);
            $display("txn rs=%0b data=%02h exec=%0d done at cycle %0d", e.rs, e.data, e.exec, cyc);
          end
        end
        en_prev = lcd_en_o;
      end
    end
  end

  initial begin
    int n, en_at, d0, k;
    rst_n_i   = 1'b0;
    lcd_reg_i = 32'h0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_status", status_o, 32'h0);
    chk("rst_en", {31'b0, lcd_en_o}, 32'd0);
    chk("rst_on", {31'b0, lcd_on_o}, 32'd0);
    chk("rst_bus", {23'b0, lcd_rs_o, lcd_data_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    // Normal command: EN in the 5th cycle after capture, busy 2018 cycles.
    d0 = n_done;
    issue(1'b0, 8'h38, 1'b1);
    @(posedge clk_i);
    run_to_idle(3000, n, en_at);
    chk("t1_busy_len", n, TS + TP + TH + TE);
    chk("t1_en_start", en_at, TS);
    chk("t1_done_cnt", n_done - d0, 1);
    chk("t1_bus_hold", {23'b0, lcd_rs_o, lcd_data_o}, {23'b0, 1'b0, 8'h38});
    chk("t1_status", status_o, 32'h0);

    set_on(1'b1);

    // Clear display takes the long wait.
    d0 = n_done;
    issue(1'b0, 8'h01, 1'b1);
    @(posedge clk_i);
    run_to_idle(TL + 100, n, en_at);
    chk("t2_busy_len", n, TS + TP + TH + TL);
    chk("t2_done_cnt", n_done - d0, 1);

    // Two data writes 100 cycles apart: second waits in the pending slot.
    d0 = n_done;
    issue(1'b1, 8'h41, 1'b1);
    repeat (98) @(posedge clk_i);
    issue(1'b1, 8'h42, 1'b1);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("t3_pend", status_o, 32'h3);
    set_on(1'b0);
    run_to_idle(5000, n, en_at);
    chk("t3_en_gap", gap, TH + TE + TS);
    chk("t3_status", status_o, 32'h0);
    chk("t3_done_cnt", n_done - d0, 2);
    chk("t3_bus_hold", {23'b0, lcd_rs_o, lcd_data_o}, {23'b0, 1'b1, 8'h42});

    // Three requests in one transaction: the third is dropped, ovf sticks.
    d0 = n_done;
    issue(1'b0, 8'h80, 1'b1);
    issue(1'b1, 8'h55, 1'b1);
    issue(1'b1, 8'h66, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("t4_status_full", status_o, 32'h7);
    run_to_idle(5000, n, en_at);
    chk("t4_ovf_sticky", status_o, 32'h4);
    chk("t4_done_cnt", n_done - d0, 2);
    chk("t4_last_bus", {23'b0, lcd_rs_o, lcd_data_o}, {23'b0, 1'b1, 8'h55});
    issue(1'b1, 8'h20, 1'b1);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("t4_ovf_clear", status_o, 32'h1);

    // Reset during the EN pulse aborts the transaction.
    k = 0;
    while (!lcd_en_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    chk("t5_en_seen", {31'b0, lcd_en_o}, 32'd1);
    #2;
    rst_n_i = 1'b0;
    sb.delete();
    d0 = n_done;
    #1;
    chk("t5_en_drop", {31'b0, lcd_en_o}, 32'd0);
    chk("t5_status", status_o, 32'h0);
    chk("t5_done", {31'b0, done_o}, 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("t5_go_held", status_o, 32'h0);
    chk("t5_no_done", n_done - d0, 0);
    issue(1'b0, 8'h0C, 1'b1);
    @(posedge clk_i);
    run_to_idle(3000, n, en_at);
    chk("t5_restart_len", n, TS + TP + TH + TE);
    chk("t5_done_cnt", n_done - d0, 1);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
